// File: rtl/sram_fifo_pkg.sv
// Shared types and elaboration helpers for the SRAM FIFO write-path arbiter.
package sram_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  // Word layout: data bytes, 8-bit keep summary, EOP flag in the MSB.
  function automatic int word_width(input int tdata_width);
    return 32'sd8 * tdata_width + 32'sd9;
  endfunction

  function automatic int eop_bit(input int tdata_width);
    return word_width(tdata_width) - 32'sd1;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request after ptr, wrapping modulo NUM_QUEUES.
module rr_pick #(
  parameter int NUM_QUEUES = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic [NUM_QUEUES-1:0] req,
  input  logic [ID_WIDTH-1:0]   ptr,
  output logic [ID_WIDTH-1:0]   grant,
  output logic                  any_grant
);

  logic [ID_WIDTH-1:0] idx_s;
  logic                hit_s;

  // Scan ptr+1 .. ptr+NUM_QUEUES; the first hit wins and later hits are masked.
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    idx_s     = '0;
    hit_s     = 1'b0;
    for (int i = 1; i <= NUM_QUEUES; i++) begin
      idx_s     = ID_WIDTH'((int'(ptr) + i) % NUM_QUEUES);
      hit_s     = ~any_grant & req[idx_s];
      grant     = hit_s ? idx_s : grant;
      any_grant = any_grant | hit_s;
    end
  end

endmodule

// File: rtl/sram_fifo_burst_arbiter.sv
// Burst-granular round-robin arbiter feeding the SRAM write engine from
// NUM_QUEUES head-word streams through a registered valid/ready output.
module sram_fifo_burst_arbiter
  import sram_fifo_pkg::*;
#(
  parameter int TDATA_WIDTH    = 32,
  parameter int NUM_QUEUES     = 4,
  parameter int QUEUE_ID_WIDTH = 2,
  parameter int BURST_LEN      = 8,
  parameter int IDLE_TIMEOUT   = 16,
  localparam int W             = word_width(TDATA_WIDTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_QUEUES-1:0]     din_valid,
  input  logic [NUM_QUEUES*W-1:0]   din,
  output logic [NUM_QUEUES-1:0]     rd_en,
  input  logic [NUM_QUEUES-1:0]     mem_queue_full,
  output logic [W-1:0]              dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [QUEUE_ID_WIDTH-1:0] queue_id,
  output logic                      burst_start,
  output logic                      burst_end
);

  localparam int EOP_BIT = eop_bit(TDATA_WIDTH);
  localparam int BW      = clog2(BURST_LEN) + 32'sd1;
  localparam int IW      = clog2(IDLE_TIMEOUT) + 32'sd1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 32'sd1);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1'b1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 32'sd1);
  localparam logic [IW-1:0] IDLE_ONE  = IW'(1'b1);
  localparam logic [QUEUE_ID_WIDTH-1:0] PTR_INIT = QUEUE_ID_WIDTH'(NUM_QUEUES - 32'sd1);

  arb_state_e                state_r, state_nxt_s;
  logic [QUEUE_ID_WIDTH-1:0] grant_r, rr_ptr_r, pick_s, queue_id_r;
  logic                      any_s;
  logic [BW-1:0]             beat_cnt_r;
  logic [IW-1:0]             idle_cnt_r;
  logic                      end_pending_r;
  logic [W-1:0]              dout_r, head_s;
  logic                      dout_valid_r, burst_start_r, burst_end_r;
  logic [NUM_QUEUES-1:0]     eligible_s;
  logic                      head_valid_s, can_load_s, pop_s, last_s, timeout_s, close_s;

  assign eligible_s   = din_valid & ~mem_queue_full;
  assign head_s       = din[int'(grant_r) * W +: W];
  assign head_valid_s = din_valid[grant_r];
  assign can_load_s   = ~dout_valid_r | dout_ready;
  assign pop_s        = (state_r == ST_BURST) & head_valid_s & can_load_s;
  assign last_s       = (beat_cnt_r == BEAT_LAST) | head_s[EOP_BIT];
  assign timeout_s    = (state_r == ST_BURST) & ~head_valid_s & (idle_cnt_r == IDLE_LAST);
  assign close_s      = timeout_s & (beat_cnt_r != '0);
  assign rd_en        = pop_s ? (NUM_QUEUES'(1'b1) << grant_r) : '0;

  rr_pick #(
    .NUM_QUEUES (NUM_QUEUES),
    .ID_WIDTH   (QUEUE_ID_WIDTH)
  ) u_rr_pick (
    .req       (eligible_s),
    .ptr       (rr_ptr_r),
    .grant     (pick_s),
    .any_grant (any_s)
  );

  // Next-state decode; a timeout with nothing emitted skips DRAIN entirely.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_s) state_nxt_s = ST_BURST;
        else       state_nxt_s = ST_IDLE;
      end
      ST_BURST: begin
        if ((pop_s & last_s) | close_s) state_nxt_s = ST_DRAIN;
        else if (timeout_s)             state_nxt_s = ST_IDLE;
        else                            state_nxt_s = ST_BURST;
      end
      ST_DRAIN: begin
        if (can_load_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register, grant/pointer capture and burst counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      grant_r       <= '0;
      rr_ptr_r      <= PTR_INIT;
      beat_cnt_r    <= '0;
      idle_cnt_r    <= '0;
      end_pending_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            grant_r    <= pick_s;
            rr_ptr_r   <= pick_s;
            beat_cnt_r <= '0;
            idle_cnt_r <= '0;
          end
        end
        ST_BURST: begin
          if (pop_s) begin
            beat_cnt_r <= beat_cnt_r + BEAT_ONE;
            idle_cnt_r <= '0;
          end else if (!head_valid_s) begin
            idle_cnt_r <= idle_cnt_r + IDLE_ONE;
          end
          if (close_s) end_pending_r <= 1'b1;
        end
        ST_DRAIN: begin
          if (can_load_s) end_pending_r <= 1'b0;
        end
        default: end_pending_r <= 1'b0;
      endcase
    end
  end

  // Output register: load on pop, drop on accept, otherwise hold; a timeout
  // close can still mark a held word as the end of its burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_r        <= '0;
      dout_valid_r  <= 1'b0;
      queue_id_r    <= '0;
      burst_start_r <= 1'b0;
      burst_end_r   <= 1'b0;
    end else if (pop_s) begin
      dout_r        <= head_s;
      dout_valid_r  <= 1'b1;
      queue_id_r    <= grant_r;
      burst_start_r <= (beat_cnt_r == '0);
      burst_end_r   <= last_s;
    end else if (dout_ready) begin
      dout_valid_r  <= 1'b0;
      burst_start_r <= 1'b0;
      burst_end_r   <= 1'b0;
    end else if (dout_valid_r & (close_s | end_pending_r)) begin
      burst_end_r   <= 1'b1;
    end
  end

  assign dout        = dout_r;
  assign dout_valid  = dout_valid_r;
  assign queue_id    = queue_id_r;
  assign burst_start = burst_start_r;
  assign burst_end   = burst_end_r;

endmodule

// File: tb/tb_sram_fifo_burst_arbiter.sv
// Directed scoreboard bench for sram_fifo_burst_arbiter (4 queues, bursts of 8).
module tb_sram_fifo_burst_arbiter;
  import sram_fifo_pkg::*;

  localparam int TW    = 32;
  localparam int NQ    = 4;
  localparam int QW    = 2;
  localparam int BL    = 8;
  localparam int IT    = 16;
  localparam int W     = word_width(TW);
  localparam int DEPTH = 64;
  localparam int CW    = W + QW + 2;

  typedef struct packed {
    logic [W-1:0]  w;
    logic [QW-1:0] q;
    logic          s;
    logic          e;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [NQ-1:0]   din_valid, rd_en, mem_queue_full;
  logic [NQ*W-1:0] din;
  logic [W-1:0]    dout;
  logic            dout_valid, dout_ready;
  logic [QW-1:0]   queue_id;
  logic            burst_start, burst_end;

  logic [W-1:0] mem [NQ][DEPTH];
  int           head [NQ];
  int           tail [NQ];
  exp_t         sb [$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           cyc      = 0;
  int           last_hs  = 0;
  logic         last_end = 1'b0;
  logic         gap_en   = 1'b0;

  sram_fifo_burst_arbiter #(
    .TDATA_WIDTH    (TW),
    .NUM_QUEUES     (NQ),
    .QUEUE_ID_WIDTH (QW),
    .BURST_LEN      (BL),
    .IDLE_TIMEOUT   (IT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .din_valid      (din_valid),
    .din            (din),
    .rd_en          (rd_en),
    .mem_queue_full (mem_queue_full),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
    .queue_id       (queue_id),
    .burst_start    (burst_start),
    .burst_end      (burst_end)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk_word(input int q, input int i, input logic eop);
    logic [W-1:0] w;
    w          = '0;
    w[7:0]     = i[7:0];
    w[15:8]    = q[7:0];
    w[64 +: 32] = 32'hC0DE_0000 ^ (i * 32'd977 + q * 32'd31);
    w[W-2 -: 8] = 8'hFF;
    w[W-1]     = eop;
    return w;
  endfunction

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic load(input int q, input int i, input logic eop);
    mem[q][tail[q]] = mk_word(q, i, eop);
    tail[q]++;
  endtask

  task automatic exp_word(input int q, input int i, input logic eop, input logic s, input logic e);
    exp_t x;
    x.w = mk_word(q, i, eop);
    x.q = QW'(q);
    x.s = s;
    x.e = e;
    sb.push_back(x);
  endtask

  task automatic refresh();
    for (int q = 0; q < NQ; q++) begin
      din_valid[q]     = (head[q] < tail[q]);
      din[q*W +: W]    = (head[q] < tail[q]) ? mem[q][head[q]] : '0;
    end
  endtask

  // One clock: check outputs at negedge, then apply the pops the DUT made.
  task automatic tick();
    logic [NQ-1:0] pops;
    exp_t          got;
    exp_t          ex;
    @(negedge clk);
    cyc++;
    check("pop_while_held", {1'b0, ((|rd_en) & dout_valid & ~dout_ready)}, '0);
    if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
      got.w = dout;
      got.q = queue_id;
      got.s = burst_start;
      got.e = burst_end;
      check("word_expected", {1'b0, (sb.size() != 0)}, 1);
      if (sb.size() != 0) begin
        ex = sb.pop_front();
        check("word", got, ex);
        if (gap_en && got.s && last_end) check("burst_gap", cyc - last_hs, 3);
        last_hs  = cyc;
        last_end = got.e;
      end
    end
    pops = rd_en;
    @(posedge clk);
    #1;
    for (int q = 0; q < NQ; q++) begin
      if (pops[q] === 1'b1) begin
        check("pop_nonempty", {1'b0, (head[q] < tail[q])}, 1);
        head[q]++;
      end
    end
    refresh();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", {1'b0, (sb.size() == 0)}, 1);
    sb.delete();
  endtask

  initial begin
    reset          = 1'b1;
    dout_ready     = 1'b1;
    mem_queue_full = '0;
    for (int q = 0; q < NQ; q++) begin
      head[q] = 0;
      tail[q] = 0;
    end
    refresh();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t1_valid", dout_valid, 0);
      check("t1_rd_en", rd_en, 0);
    end
    check("t1_qid", queue_id, 0);
    check("t1_start", burst_start, 0);
    check("t1_end", burst_end, 0);

    // Four full queues: 8,8,4-word bursts per queue in order 0,1,2,3; the
    // 4-word tails close silently by timeout after the last word left.
    for (int q = 0; q < NQ; q++)
      for (int i = 0; i < 20; i++) load(q, i, 1'b0);
    for (int r = 0; r < 3; r++)
      for (int q = 0; q < NQ; q++)
        for (int k = 0; k < ((r < 2) ? 8 : 4); k++)
          exp_word(q, r * 8 + k, 1'b0, (k == 0), (r < 2) && (k == 7));
    gap_en   = 1'b1;
    last_end = 1'b0;
    refresh();
    drain(800);
    gap_en = 1'b0;
    repeat (25) tick();

    // EOP-terminated short burst on queue 2
    for (int i = 0; i < 3; i++) begin
      load(2, 100 + i, (i == 2));
      exp_word(2, 100 + i, (i == 2), (i == 0), (i == 2));
    end
    refresh();
    drain(50);
    repeat (3) tick();
    check("t3_idle", dut.state_r, ST_IDLE);

    // Single EOP word on queue 0 leaves the pointer at 0
    load(0, 110, 1'b1);
    exp_word(0, 110, 1'b1, 1'b1, 1'b1);
    refresh();
    drain(50);
    repeat (3) tick();

    // Queue 1 full: grants 2,3,0,2; full[2] raised mid-burst is ignored
    mem_queue_full = 4'b0010;
    for (int i = 0; i < 16; i++) load(2, 120 + i, 1'b0);
    for (int i = 0; i < 8; i++) begin
      load(3, 120 + i, 1'b0);
      load(0, 120 + i, 1'b0);
      load(1, 120 + i, 1'b0);
    end
    for (int i = 0; i < 8; i++) exp_word(2, 120 + i, 1'b0, (i == 0), (i == 7));
    for (int i = 0; i < 8; i++) exp_word(3, 120 + i, 1'b0, (i == 0), (i == 7));
    for (int i = 0; i < 8; i++) exp_word(0, 120 + i, 1'b0, (i == 0), (i == 7));
    for (int i = 8; i < 16; i++) exp_word(2, 120 + i, 1'b0, (i == 8), (i == 15));
    refresh();
    repeat (4) tick();
    mem_queue_full[2] = 1'b1;
    repeat (4) tick();
    mem_queue_full[2] = 1'b0;
    drain(200);
    repeat (5) tick();
    check("t4_q1_untouched", head[1], 20);
    mem_queue_full = '0;
    for (int i = 0; i < 8; i++) exp_word(1, 120 + i, 1'b0, (i == 0), (i == 7));
    drain(60);
    repeat (3) tick();

    // Queue 3: two words, then stall with the second word held downstream
    load(3, 140, 1'b0);
    load(3, 141, 1'b0);
    exp_word(3, 140, 1'b0, 1'b1, 1'b0);
    exp_word(3, 141, 1'b0, 1'b0, 1'b1);
    refresh();
    repeat (3) tick();
    dout_ready = 1'b0;
    repeat (10) tick();
    check("t5_hold_valid", dout_valid, 1);
    check("t5_hold_word", dout, mk_word(3, 141, 1'b0));
    check("t5_end_early", burst_end, 0);
    load(0, 150, 1'b1);
    exp_word(0, 150, 1'b1, 1'b1, 1'b1);
    refresh();
    repeat (20) tick();
    check("t5_end_set", burst_end, 1);
    check("t5_still_valid", dout_valid, 1);
    check("t5_qid", queue_id, 3);
    check("t5_no_pop", rd_en, 0);
    dout_ready = 1'b1;
    drain(20);
    repeat (3) tick();

    // Toggling ready 1,0,0,1 through a queue-1 burst
    for (int i = 0; i < 8; i++) begin
      load(1, 160 + i, 1'b0);
      exp_word(1, 160 + i, 1'b0, (i == 0), (i == 7));
    end
    refresh();
    for (int i = 0; i < 32; i++) begin
      dout_ready = ((i % 4) == 0) || ((i % 4) == 3);
      tick();
    end
    dout_ready = 1'b1;
    drain(30);
    repeat (3) tick();
    check("final_idle", dut.state_r, ST_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
